// File: rtl/fp_expand_if.sv
// Handshake bundle for the float-to-linear expander: compressed sample in,
// 12-bit two's-complement linear value out.
interface fp_expand_if;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [2:0]  exponent;
    logic [3:0]  significand;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] dout;

    modport master (
        output in_valid, sign, exponent, significand, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, sign, exponent, significand, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/fp_expand.sv
// Serial expander: sign/exponent/significand to 12-bit two's complement,
// one left shift per cycle, registered valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample
// SHIFT | shifting mag left once per cycle until count reaches zero
// SIGN  | apply sign to mag and load dout
// HOLD  | out_valid high, waiting for out_ready
module fp_expand (
    input  logic        clk,
    input  logic        rst_n,
    fp_expand_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    logic        sign_q;
    logic [2:0]  count;
    logic [10:0] mag;
    logic [11:0] mag_ext;

    assign mag_ext = {1'b0, mag};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            sign_q        <= 1'b0;
            count         <= 3'd0;
            mag           <= 11'd0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.dout      <= 12'h000;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q       <= bus.sign;
                        count        <= bus.exponent;
                        mag          <= {7'b0, bus.significand};
                        bus.in_ready <= 1'b0;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count != 3'd0) begin
                        mag   <= mag << 1;
                        count <= count - 3'd1;
                    end else begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    // Magnitude tops out at 1920, so the 12-bit negate never wraps.
                    bus.dout      <= sign_q ? (12'd0 - mag_ext) : mag_ext;
                    bus.out_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
